// File: rtl/div.sv
// Sequential 32-bit restoring divider (DIV/DIVU) feeding HI/LO.
// Level-held iniciar handshake: 32 iteration cycles plus one sign-fix cycle,
// divide-by-zero short-circuits straight to DONE.
module div (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        iniciar,
   input  logic        sinal,
   input  logic [31:0] dividendo,
   input  logic [31:0] divisor,
   output logic [31:0] quociente,
   output logic [31:0] resto,
   output logic        dividindo,
   output logic        pronto,
   output logic        div_zero
);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] dq;     // dividend magnitude shifting out, quotient bits shifting in
   logic [31:0] dvs;    // divisor magnitude
   logic [31:0] rem;    // partial remainder
   logic        neg_q, neg_r;

   logic [32:0] r_sh, r_sub;
   logic        r_ge;

   // One restoring step: shift next dividend bit into the remainder and trial-subtract.
   // r_sh < 2*dvs always holds, so the borrow bit alone tells whether r_sh >= dvs.
   always_comb begin
      r_sh  = {rem, dq[31]};
      r_sub = r_sh - {1'b0, dvs};
      r_ge  = ~r_sub[32];
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and status outputs; dropping iniciar mid-operation aborts to IDLE.
   always_comb begin
      state_nxt = state;
      dividindo = 1'b0;
      pronto    = 1'b0;
      case (state)
         S_IDLE: begin
            if (iniciar) state_nxt = (divisor == 32'd0) ? S_DONE : S_DIV;
         end
         S_DIV: begin
            dividindo = 1'b1;
            if (!iniciar)          state_nxt = S_IDLE;
            else if (cnt == 6'd31) state_nxt = S_FIX;
         end
         S_FIX: begin
            dividindo = 1'b1;
            state_nxt = iniciar ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            pronto = 1'b1;
            if (!iniciar) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iterations, sign fix, and abort clearing of results.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt       <= '0;
         dq        <= '0;
         dvs       <= '0;
         rem       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         quociente <= '0;
         resto     <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (iniciar) begin
                  dq    <= (sinal && dividendo[31]) ? -dividendo : dividendo;
                  dvs   <= (sinal && divisor[31])   ? -divisor   : divisor;
                  neg_q <= sinal & (dividendo[31] ^ divisor[31]);
                  neg_r <= sinal & dividendo[31];
                  cnt   <= '0;
                  rem   <= '0;
                  if (divisor == 32'd0) begin
                     div_zero  <= 1'b1;
                     quociente <= '0;
                     resto     <= dividendo;
                  end else begin
                     div_zero  <= 1'b0;
                     quociente <= '0;
                     resto     <= '0;
                  end
               end
            end
            S_DIV: begin
               if (!iniciar) begin
                  quociente <= '0;
                  resto     <= '0;
                  div_zero  <= 1'b0;
               end else begin
                  rem <= r_ge ? r_sub[31:0] : r_sh[31:0];
                  dq  <= {dq[30:0], r_ge};
                  cnt <= cnt + 6'd1;
               end
            end
            S_FIX: begin
               if (!iniciar) begin
                  quociente <= '0;
                  resto     <= '0;
                  div_zero  <= 1'b0;
               end else begin
                  // Truncation toward zero; remainder follows the dividend's sign.
                  quociente <= neg_q ? -dq  : dq;
                  resto     <= neg_r ? -rem : rem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Bench for div: arithmetic reference model checked every cycle, plus
// hand-computed directed vectors covering signs, overflow, /0, abort and reset.
module tb_div;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        iniciar;
   logic        sinal;
   logic [31:0] dividendo, divisor;
   logic [31:0] quociente, resto;
   logic        dividindo, pronto, div_zero;

   int total = 0;
   int bad   = 0;

   div dut (
      .Clk(Clk), .Reset(Reset), .iniciar(iniciar), .sinal(sinal),
      .dividendo(dividendo), .divisor(divisor),
      .quociente(quociente), .resto(resto),
      .dividindo(dividindo), .pronto(pronto), .div_zero(div_zero)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic in 64 bits: no overflow trap, low 32 bits give the wrap.
   function automatic logic [31:0] ref_q(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, lq;
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      lq = sa / sb;
      return lq[31:0];
   endfunction

   function automatic logic [31:0] ref_r(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, lr;
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      lr = sa % sb;
      return lr[31:0];
   endfunction

   // Behavioural model: remaining-cycle countdown plus a held result.
   int          m_left;
   logic        m_pr, m_dz;
   logic [31:0] m_q, m_r, p_q, p_r;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_left <= 0; m_pr <= 1'b0; m_dz <= 1'b0; m_q <= '0; m_r <= '0;
      end else if (m_left > 0) begin
         if (!iniciar) begin
            m_left <= 0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin m_pr <= 1'b1; m_q <= p_q; m_r <= p_r; end
         end
      end else if (m_pr) begin
         if (!iniciar) m_pr <= 1'b0;
      end else if (iniciar) begin
         if (divisor == 32'd0) begin
            m_pr <= 1'b1; m_q <= '0; m_r <= dividendo; m_dz <= 1'b1;
         end else begin
            m_left <= 33; m_dz <= 1'b0;
            p_q <= ref_q(sinal, dividendo, divisor);
            p_r <= ref_r(sinal, dividendo, divisor);
         end
      end
   end

   // Compare against the model on every falling edge; results only when not busy.
   always @(negedge Clk) begin
      if (Reset === 1'b1) begin
         chk("m_dividindo", {31'd0, dividindo}, {31'd0, m_left > 0});
         chk("m_pronto", {31'd0, pronto}, {31'd0, m_pr});
         if (m_left == 0) begin
            chk("m_quociente", quociente, m_q);
            chk("m_resto", resto, m_r);
            chk("m_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
         end
      end
   end

   // Start an operation (caller is at posedge+2 in IDLE) and wait for pronto.
   task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, output int n);
      sinal = s; dividendo = a; divisor = b; iniciar = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #2;
         n++;
         if (n == 1) begin dividendo = ~a; divisor = b ^ 32'h5A5A_0001; sinal = ~s; end
         if (pronto) break;
      end
      if (!pronto) chk("timeout", {31'd0, pronto}, 32'd1);
   endtask

   task automatic drop();
      iniciar = 1'b0;
      @(posedge Clk); #2;
   endtask

   task automatic expect_res(input string name, input logic [31:0] q, input logic [31:0] r, input logic dz);
      chk({name, "_q"}, quociente, q);
      chk({name, "_r"}, resto, r);
      chk({name, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
   endtask

   int n;

   initial begin
      Reset = 1'b0; iniciar = 1'b0; sinal = 1'b0; dividendo = '0; divisor = '0;
      repeat (2) @(posedge Clk);
      #2;
      expect_res("rst", 32'd0, 32'd0, 1'b0);
      chk("rst_busy", {30'd0, dividindo, pronto}, 32'd0);
      Reset = 1'b1;
      @(posedge Clk); #2;

      // Model pins: reference arithmetic against hand values.
      chk("ref_neg7_2_q", ref_q(1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("ref_ovf_q", ref_q(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

      run(1'b0, 32'd100, 32'd7, n);
      chk("u100_7_lat", n, 34);
      chk("u100_7_pronto", {31'd0, pronto}, 32'd1);
      expect_res("u100_7", 32'd14, 32'd2, 1'b0);
      drop();

      run(1'b1, 32'hFFFF_FFF9, 32'd2, n);
      expect_res("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      drop();
      run(1'b1, 32'd7, 32'hFFFF_FFFE, n);
      expect_res("s7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
      drop();
      run(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, n);
      expect_res("sm7_m2", 32'd3, 32'hFFFF_FFFF, 1'b0);
      drop();

      run(1'b0, 32'hFFFF_FFFF, 32'd1, n);
      expect_res("umax_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
      drop();
      run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n);
      expect_res("ovf", 32'h8000_0000, 32'd0, 1'b0);
      drop();

      run(1'b0, 32'h0000_1234, 32'd0, n);
      chk("dz_lat", n, 1);
      chk("dz_pronto", {31'd0, pronto}, 32'd1);
      expect_res("dz", 32'd0, 32'h0000_1234, 1'b1);
      drop();
      expect_res("dz_hold", 32'd0, 32'h0000_1234, 1'b1);

      // Abort: drop iniciar at cycle 10.
      sinal = 1'b0; dividendo = 32'd100; divisor = 32'd7; iniciar = 1'b1;
      repeat (10) begin @(posedge Clk); #2; end
      chk("abort_busy", {31'd0, dividindo}, 32'd1);
      drop();
      expect_res("abort", 32'd0, 32'd0, 1'b0);
      chk("abort_flags", {30'd0, dividindo, pronto}, 32'd0);

      // Reset at cycle 20 of a second run, effective without a clock edge.
      iniciar = 1'b1;
      repeat (20) begin @(posedge Clk); #2; end
      Reset = 1'b0;
      #1;
      expect_res("mrst", 32'd0, 32'd0, 1'b0);
      chk("mrst_flags", {30'd0, dividindo, pronto}, 32'd0);
      iniciar = 1'b0;
      @(posedge Clk); #2;
      Reset = 1'b1;
      @(posedge Clk); #2;
      run(1'b0, 32'd100, 32'd7, n);
      expect_res("post_rst", 32'd14, 32'd2, 1'b0);

      // Back-to-back: hold DONE 5 cycles, one IDLE cycle, then 9 / 3.
      repeat (5) begin @(posedge Clk); #2; end
      chk("hold_pronto", {31'd0, pronto}, 32'd1);
      drop();
      chk("idle_pronto", {31'd0, pronto}, 32'd0);
      expect_res("idle_hold", 32'd14, 32'd2, 1'b0);
      run(1'b0, 32'd9, 32'd3, n);
      chk("b2b_lat", n, 34);
      expect_res("b2b", 32'd3, 32'd0, 1'b0);
      drop();

      @(posedge Clk); #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div.md
# div

Sequential 32-bit restoring divider for the processor datapath. It is the counterpart of the shift-add multiplier and feeds the HI/LO registers for DIV/DIVU.
- It computes quotient and remainder over 32 iteration cycles plus one sign-fix cycle.
- It supports signed and unsigned operands and flags divide-by-zero.
- It uses the same level-held `iniciar` handshake as the multiplier, so the control unit drives both blocks the same way.

## Interface
- No parameters. Width is fixed at 32 bits.
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-low reset (asserted at 0)
- iniciar  input  1  start/hold request; held high by control for the whole operation
- sinal  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
- dividendo  input  32  dividend; sampled at start
- divisor  input  32  divisor; sampled at start
- quociente  output  32  quotient (to LO), registered
- resto  output  32  remainder (to HI), registered
- dividindo  output  1  busy; high in DIV and FIX states
- pronto  output  1  result valid; high in DONE state
- div_zero  output  1  divide-by-zero flag; valid while pronto=1

## Operation
- States: IDLE, DIV, FIX, DONE (2-bit encoding).
- IDLE:
  - If iniciar=0, stay in IDLE.
  - If iniciar=1 and divisor=0, latch the operands, set div_zero=1, quociente=0, resto=dividendo, and go to DONE.
  - If iniciar=1 and divisor≠0, latch the operands, clear the counter and remainder register, and go to DIV.
- Operand preparation at start:
  - When sinal=1, store the magnitude of each operand (two's-complement negate if bit 31 is set).
  - Record neg_q = dividendo[31] XOR divisor[31] and neg_r = dividendo[31].
  - When sinal=0, both neg flags are 0 and the operands are used as-is.
- DIV, one iteration per cycle:
  - Form r' = {rem[31:0], dq[31]} (33 bits) and shift dq left by 1.
  - If r' ≥ {1'b0, dvs}, set rem = r' − dvs and dq[0] = 1; otherwise rem = r'[31:0] and dq[0] = 0.
  - The counter is 6 bits. After the 32nd iteration (counter = 31), go to FIX.
- FIX:
  - quociente = neg_q ? −dq : dq
  - resto = neg_r ? −rem : rem
  - Go to DONE.
  - Result: quotient truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
- DONE:
  - pronto=1, dividindo=0, and outputs hold.
  - Stay while iniciar=1. When iniciar=0, go to IDLE; quociente, resto and div_zero keep their values until the next start.
- Abort: iniciar=0 during DIV or FIX sends the block to IDLE on the next edge. quociente, resto and div_zero clear to 0; no partial result is exposed.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quociente=0x80000000, resto=0 (32-bit wrap). No flag is raised.
- Reset (Reset=0, at any time, including mid-operation):
  - State IDLE; counter, quociente, resto, dividindo, pronto and div_zero all 0.
  - Takes effect immediately, with no clock edge needed.

## Timing
- Start edge E0: IDLE samples iniciar=1; state becomes DIV and dividindo=1 after E0.
- Edges E1..E32 perform the 32 iterations; E32 moves the state to FIX.
- E33 registers the results and moves to DONE; pronto=1 and dividindo=0 after E33.
- Latency from start edge to valid result is 33 cycles.
- Divide-by-zero: DONE after E0, giving 1-cycle latency with pronto=1 and div_zero=1.
- Outputs change only on clock edges (or on async reset). dividindo and pronto are never high at the same time.
- A new operation needs iniciar to drop for at least one cycle (DONE → IDLE) before it rises again.
- Operand inputs may change freely after E0 without affecting the result.

## Test plan
- Unsigned 100 / 7 (sinal=0), iniciar held high:
  - dividindo=1 for cycles 1–33.
  - After E33: pronto=1, quociente=14, resto=2, div_zero=0.
- Signed cases (sinal=1):
  - −7 / 2 → quociente=0xFFFFFFFD, resto=0xFFFFFFFF.
  - 7 / −2 → quociente=0xFFFFFFFD, resto=1.
  - −7 / −2 → quociente=3, resto=0xFFFFFFFF.
- Unsigned 0xFFFFFFFF / 1 → quociente=0xFFFFFFFF, resto=0. Then signed 0x80000000 / 0xFFFFFFFF → quociente=0x80000000, resto=0.
- Divisor 0, dividendo=0x1234 → one cycle after start: pronto=1, div_zero=1, quociente=0, resto=0x1234.
- Abort and reset mid-operation:
  - Drop iniciar at cycle 10 → IDLE next edge, all outputs 0.
  - Assert Reset=0 at cycle 20 of a second run → outputs 0 immediately.
  - Release reset, rerun 100 / 7 → correct result.
- Back-to-back: complete 100 / 7, hold DONE for 5 cycles, drop iniciar for 1 cycle, start 9 / 3:
  - First result holds through IDLE.
  - Second run yields quociente=3, resto=0 at 33 cycles after its start edge.
